windowed_register_file: RTL and testbench
=========================================

# windowed_register_file

Parametrised SPARC-style windowed integer register file for the processor datapath. It replaces the flat 32×32 file with 8 globals plus NWINDOWS overlapping windows, and provides:
- a current-window pointer (CWP) with SAVE/RESTORE stepping;
- a window-invalid mask (WIM) that raises overflow/underflow traps;
- two combinational read ports and one clocked write port.

It sits between instruction decode, which supplies the register numbers, and the ALU operand muxes and writeback.

## Interface
Parameters:
- WIDTH, 32, data width of every register.
- NWINDOWS, 8, number of register windows, legal range 2..32.
- CWP_W, $clog2(NWINDOWS), width of the CWP.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- ra  in  5  port A architectural register number.
- rb  in  5  port B architectural register number.
- rd  in  5  write register number.
- wr_data  in  WIDTH  write data.
- rf_ld  in  1  write enable.
- save  in  1  SAVE request.
- restore  in  1  RESTORE request.
- cwp_ld  in  1  load CWP from cwp_in.
- cwp_in  in  CWP_W  new CWP value.
- wim_ld  in  1  load WIM from wim_in.
- wim_in  in  NWINDOWS  new WIM value.
- pa  out  WIDTH  port A data.
- pb  out  WIDTH  port B data.
- cwp  out  CWP_W  current window pointer.
- wim  out  NWINDOWS  current window-invalid mask.
- wovf  out  1  window-overflow trap pulse.
- wunf  out  1  window-underflow trap pulse.

## Operation
Physical storage:
- 8 + 16×NWINDOWS entries of WIDTH bits.
- Entries 0..7 are globals g0..g7.
- Each window w owns 16 entries starting at P(w) = 8 + 16w: its 8 outs, then its 8 locals.

Mapping of architectural register r in window cwp:
- r 0..7 → r.
- r 8..15 (outs) → P(cwp) + (r−8).
- r 16..23 (locals) → P(cwp) + 8 + (r−16).
- r 24..31 (ins) → P((cwp+1) mod NWINDOWS) + (r−24).
- The ins of window w are therefore the outs of window w+1.

Register r0:
- Reads of r0 always return 0.
- Writes to r0 are dropped.

Write:
- When rf_ld=1 and rd≠0, mapped(rd, current cwp) ← wr_data at the clock edge.
- The write always uses the CWP value from before the edge, even when a window change occurs in the same cycle.

Window control, with priority cwp_ld > save/restore:
- **cwp_ld=1:** cwp ← cwp_in mod NWINDOWS; save/restore are ignored that cycle.
- **save=1, restore=0:** target t = (cwp−1) mod NWINDOWS. If wim[t]=1, then wovf=1 and cwp is unchanged; otherwise cwp ← t.
- **restore=1, save=0:** target t = (cwp+1) mod NWINDOWS. If wim[t]=1, then wunf=1 and cwp is unchanged; otherwise cwp ← t.
- **save=1 and restore=1:** no CWP change and no trap.
- **wim_ld=1:** wim ← wim_in at the same edge.
- A save/restore trap check in that same cycle uses the old WIM.
- CWP arithmetic wraps modulo NWINDOWS: 0−1 gives NWINDOWS−1, and NWINDOWS−1+1 gives 0.

## Timing
Reset (rst_n=0 at a rising edge):
- All physical registers ← 0.
- cwp ← 0.
- wim ← 1<<1, so window 1 is invalid.
- wovf = wunf = 0.
- pa and pb read 0 from the next cycle.
- Reset asserted mid-operation overrides every other input in that cycle.

Read ports:
- pa and pb are combinational from ra, rb, cwp and storage, with zero-cycle latency.
- After a CWP change, reads reflect the new window in the cycle after the edge.

Write latency:
- Written data is visible on the read ports the cycle after the edge, subject to the RF_BYPASS_EN behaviour below.

Trap pulses:
- wovf and wunf are registered.
- They are high for exactly the one cycle following the offending request edge.
- Back-to-back faulting requests give consecutive pulses.

## Configuration
RF_BYPASS_EN:
- **Defined:** when rf_ld=1, rd≠0, and ra (or rb) maps to the same physical entry as rd under the current cwp, pa (or pb) returns wr_data combinationally in that same cycle.
  - Aliasing counts: outs r8..15 in window w+1 and ins r24..31 in window w map to the same entry, so bypass applies.
- **Undefined:** the ports return the stored old value until the edge.
- r0 is never bypassed.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles, then release → pa=pb=0 for all ra/rb, cwp=0, wim=0x02, wovf=wunf=0.
- **Globals and r0:** write r3=0xDEADBEEF, then r0=0x1234 → ra=3 reads 0xDEADBEEF; ra=0 reads 0.
- **Window overlap:** at cwp=0, write r8=0xA5A5A5A5, then save → cwp=7 and r24 reads 0xA5A5A5A5. Restore → cwp=0 and r8 reads 0xA5A5A5A5. Locals r16 are distinct between windows.
- **Overflow/underflow:** from reset, issue 6 saves → cwp=2. A 7th save → wovf=1 for one cycle and cwp stays 2. From reset, a restore → wunf=1 and cwp stays 0.
- **Simultaneous events:** save+restore together → no change, no trap. cwp_ld=5 with save → cwp=5. Write r16 with save in the same cycle → the data lands in the old window's local.
- **Bypass:** rf_ld=1, rd=ra=9, wr_data=0x55 → pa=0x55 in the same cycle with RF_BYPASS_EN defined, and the old value without it.

Source files
------------

// File: rtl/windowed_register_file_if.sv
// Register-file port bundle: decode/writeback/window-control side and
// read-data/trap side of the windowed integer register file.
interface windowed_register_file_if #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS)
);
    logic [4:0]          ra;
    logic [4:0]          rb;
    logic [4:0]          rd;
    logic [WIDTH-1:0]    wr_data;
    logic                rf_ld;
    logic                save;
    logic                restore;
    logic                cwp_ld;
    logic [CWP_W-1:0]    cwp_in;
    logic                wim_ld;
    logic [NWINDOWS-1:0] wim_in;
    logic [WIDTH-1:0]    pa;
    logic [WIDTH-1:0]    pb;
    logic [CWP_W-1:0]    cwp;
    logic [NWINDOWS-1:0] wim;
    logic                wovf;
    logic                wunf;

    modport master (
        output ra, rb, rd, wr_data, rf_ld,
        output save, restore, cwp_ld, cwp_in, wim_ld, wim_in,
        input  pa, pb, cwp, wim, wovf, wunf
    );

    modport slave (
        input  ra, rb, rd, wr_data, rf_ld,
        input  save, restore, cwp_ld, cwp_in, wim_ld, wim_in,
        output pa, pb, cwp, wim, wovf, wunf
    );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: 8 globals + NWINDOWS overlapping windows.
// Optional RF_BYPASS_EN forwards same-cycle write data onto the read ports.
module windowed_register_file #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    windowed_register_file_if.slave   bus
);
    localparam int NPHYS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NPHYS);
    localparam logic [CWP_W:0]   NW   = (CWP_W+1)'(NWINDOWS);
    localparam logic [CWP_W-1:0] LAST = CWP_W'(NWINDOWS - 1);

    logic [WIDTH-1:0]    r_mem [NPHYS];
    logic [CWP_W-1:0]    r_cwp;
    logic [NWINDOWS-1:0] r_wim;
    logic                r_wovf;
    logic                r_wunf;

    logic [CWP_W-1:0]    w_cwp_inc;
    logic [CWP_W-1:0]    w_cwp_dec;
    logic [CWP_W-1:0]    w_cwp_ldv;
    logic [CWP_W-1:0]    w_cwp_nxt;
    logic                w_ovf_nxt;
    logic                w_unf_nxt;
    logic                w_wen;
    logic [PW-1:0]       w_ia;
    logic [PW-1:0]       w_ib;
    logic [PW-1:0]       w_iw;
    logic [WIDTH-1:0]    w_pa;
    logic [WIDTH-1:0]    w_pb;

    // Ins resolve into the outs of the next window (wn = cwp+1 wrapped).
    function automatic logic [PW-1:0] f_map(
        input logic [4:0]       r,
        input logic [CWP_W-1:0] w,
        input logic [CWP_W-1:0] wn
    );
        logic [PW-1:0] base;
        logic [PW-1:0] basen;
        logic [PW-1:0] off;
        base  = PW'(8) + PW'({w, 4'b0000});
        basen = PW'(8) + PW'({wn, 4'b0000});
        off   = PW'(r[2:0]);
        unique case (r[4:3])
            2'b00:   f_map = off;
            2'b01:   f_map = base + off;
            2'b10:   f_map = base + PW'(8) + off;
            default: f_map = basen + off;
        endcase
    endfunction

    assign w_cwp_inc = (r_cwp == LAST) ? '0 : r_cwp + 1'b1;
    assign w_cwp_dec = (r_cwp == '0) ? LAST : r_cwp - 1'b1;
    // cwp_in spans less than 2*NWINDOWS, so one subtraction is a full modulo.
    assign w_cwp_ldv = ({1'b0, bus.cwp_in} >= NW)
                     ? bus.cwp_in - NW[CWP_W-1:0] : bus.cwp_in;

    assign w_wen = bus.rf_ld && (bus.rd != 5'd0);
    assign w_ia  = f_map(bus.ra, r_cwp, w_cwp_inc);
    assign w_ib  = f_map(bus.rb, r_cwp, w_cwp_inc);
    assign w_iw  = f_map(bus.rd, r_cwp, w_cwp_inc);

    always_comb begin
        w_cwp_nxt = r_cwp;
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;
        if (bus.cwp_ld) begin
            w_cwp_nxt = w_cwp_ldv;
        end else if (bus.save && !bus.restore) begin
            if (r_wim[w_cwp_dec]) w_ovf_nxt = 1'b1;
            else                  w_cwp_nxt = w_cwp_dec;
        end else if (bus.restore && !bus.save) begin
            if (r_wim[w_cwp_inc]) w_unf_nxt = 1'b1;
            else                  w_cwp_nxt = w_cwp_inc;
        end
    end

    always_comb begin
        w_pa = (bus.ra == 5'd0) ? '0 : r_mem[w_ia];
        w_pb = (bus.rb == 5'd0) ? '0 : r_mem[w_ib];
`ifdef RF_BYPASS_EN
        if (w_wen && bus.ra != 5'd0 && w_ia == w_iw) w_pa = bus.wr_data;
        if (w_wen && bus.rb != 5'd0 && w_ib == w_iw) w_pb = bus.wr_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPHYS; i++) r_mem[i] <= '0;
            r_cwp  <= '0;
            r_wim  <= NWINDOWS'(2);
            r_wovf <= 1'b0;
            r_wunf <= 1'b0;
        end else begin
            if (w_wen) r_mem[w_iw] <= bus.wr_data;
            r_cwp  <= w_cwp_nxt;
            r_wovf <= w_ovf_nxt;
            r_wunf <= w_unf_nxt;
            if (bus.wim_ld) r_wim <= bus.wim_in;
        end
    end

    assign bus.pa   = w_pa;
    assign bus.pb   = w_pb;
    assign bus.cwp  = r_cwp;
    assign bus.wim  = r_wim;
    assign bus.wovf = r_wovf;
    assign bus.wunf = r_wunf;
endmodule

// File: tb/tb_windowed_register_file.sv
// Bench for windowed_register_file: directed scenarios plus random traffic
// compared every cycle against an architectural model of the window file.
module tb_windowed_register_file;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int CW = $clog2(N);
    localparam int NP = 8 + 16 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    windowed_register_file_if #(.WIDTH(W), .NWINDOWS(N)) bus ();

    windowed_register_file #(.WIDTH(W), .NWINDOWS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_mem [NP];
    int           m_cwp;
    logic [N-1:0] m_wim;
    logic         m_wovf;
    logic         m_wunf;
    bit           m_valid = 1'b0;

    function automatic int pidx(input int r, input int w);
        if (r < 8)  return r;
        if (r < 16) return 8 + 16 * w + (r - 8);
        if (r < 24) return 8 + 16 * w + 8 + (r - 16);
        return 8 + 16 * ((w + 1) % N) + (r - 24);
    endfunction

    function automatic logic [W-1:0] exp_read(input int r);
        if (r == 0) return '0;
`ifdef RF_BYPASS_EN
        if (bus.rf_ld && bus.rd != 0 &&
            pidx(r, m_cwp) == pidx(int'(bus.rd), m_cwp))
            return bus.wr_data;
`endif
        return m_mem[pidx(r, m_cwp)];
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference state advances with the same edge the DUT samples.
    always @(posedge clk) begin
        int t;
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) m_mem[i] = '0;
            m_cwp = 0; m_wim = N'(2); m_wovf = 0; m_wunf = 0; m_valid = 1;
        end else if (m_valid) begin
            m_wovf = 0; m_wunf = 0;
            if (bus.rf_ld && bus.rd != 0)
                m_mem[pidx(int'(bus.rd), m_cwp)] = bus.wr_data;
            if (bus.cwp_ld) begin
                m_cwp = int'(bus.cwp_in) % N;
            end else if (bus.save && !bus.restore) begin
                t = (m_cwp + N - 1) % N;
                if (m_wim[t]) m_wovf = 1; else m_cwp = t;
            end else if (bus.restore && !bus.save) begin
                t = (m_cwp + 1) % N;
                if (m_wim[t]) m_wunf = 1; else m_cwp = t;
            end
            if (bus.wim_ld) m_wim = bus.wim_in;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pa", bus.pa, exp_read(int'(bus.ra)));
            chk("pb", bus.pb, exp_read(int'(bus.rb)));
            chk("cwp", W'(bus.cwp), W'(m_cwp));
            chk("wim", W'(bus.wim), W'(m_wim));
            chk("wovf", W'(bus.wovf), W'(m_wovf));
            chk("wunf", W'(bus.wunf), W'(m_wunf));
        end
    end

    task automatic idle();
        bus.rf_ld = 0; bus.save = 0; bus.restore = 0;
        bus.cwp_ld = 0; bus.wim_ld = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input int a, input int b);
        bus.ra = 5'(a); bus.rb = 5'(b);
        #1;
    endtask

    task automatic wr(input int r, input logic [W-1:0] d);
        bus.rd = 5'(r); bus.wr_data = d; bus.rf_ld = 1;
        tick();
        bus.rf_ld = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0; tick(); tick(); rst_n = 1;
    endtask

    initial begin
        idle();
        bus.ra = 0; bus.rb = 0; bus.rd = 0; bus.wr_data = '0;
        bus.cwp_in = '0; bus.wim_in = '0;

        do_reset();
        chk("rst_cwp", W'(bus.cwp), 32'd0);
        chk("rst_wim", W'(bus.wim), 32'h02);
        chk("rst_wovf", W'(bus.wovf), 32'd0);
        chk("rst_wunf", W'(bus.wunf), 32'd0);
        for (int r = 0; r < 32; r++) begin
            look(r, 31 - r);
            chk("rst_pa", bus.pa, 32'd0);
            chk("rst_pb", bus.pb, 32'd0);
            tick();
        end

        wr(3, 32'hDEADBEEF);
        wr(0, 32'h00001234);
        look(3, 0);
        chk("glob_r3", bus.pa, 32'hDEADBEEF);
        chk("glob_r0", bus.pb, 32'd0);

        wr(8, 32'hA5A5A5A5);
        bus.save = 1; tick(); bus.save = 0;
        chk("ovl_cwp7", W'(bus.cwp), 32'd7);
        look(24, 8);
        chk("ovl_r24", bus.pa, 32'hA5A5A5A5);
        bus.restore = 1; tick(); bus.restore = 0;
        chk("ovl_cwp0", W'(bus.cwp), 32'd0);
        look(8, 0);
        chk("ovl_r8", bus.pa, 32'hA5A5A5A5);
        wr(16, 32'h11);
        bus.save = 1; tick(); bus.save = 0;
        wr(16, 32'h22);
        look(16, 0);
        chk("loc_w7", bus.pa, 32'h22);
        bus.restore = 1; tick(); bus.restore = 0;
        look(16, 0);
        chk("loc_w0", bus.pa, 32'h11);

        do_reset();
        bus.save = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("ovf_cwp2", W'(bus.cwp), 32'd2);
        tick();
        chk("ovf_p1", W'(bus.wovf), 32'd1);
        chk("ovf_cwp", W'(bus.cwp), 32'd2);
        tick();
        chk("ovf_p2", W'(bus.wovf), 32'd1);
        bus.save = 0; tick();
        chk("ovf_end", W'(bus.wovf), 32'd0);

        do_reset();
        bus.restore = 1; tick(); bus.restore = 0;
        chk("unf_p", W'(bus.wunf), 32'd1);
        chk("unf_cwp", W'(bus.cwp), 32'd0);
        tick();
        chk("unf_end", W'(bus.wunf), 32'd0);

        bus.save = 1; bus.restore = 1; tick(); idle();
        chk("sr_cwp", W'(bus.cwp), 32'd0);
        chk("sr_trap", W'({bus.wovf, bus.wunf}), 32'd0);
        bus.cwp_ld = 1; bus.cwp_in = 3'd5; bus.save = 1; tick(); idle();
        chk("ld_cwp", W'(bus.cwp), 32'd5);
        bus.rd = 16; bus.wr_data = 32'hCAFE; bus.rf_ld = 1; bus.save = 1;
        tick(); idle();
        chk("ws_cwp", W'(bus.cwp), 32'd4);
        look(16, 0);
        chk("ws_new", bus.pa, 32'd0);
        bus.restore = 1; tick(); idle();
        look(16, 0);
        chk("ws_old", bus.pa, 32'hCAFE);

        bus.rd = 9; bus.wr_data = 32'h55; bus.rf_ld = 1;
        look(9, 9);
`ifdef RF_BYPASS_EN
        chk("byp_pa", bus.pa, 32'h55);
`else
        chk("byp_pa", bus.pa, 32'h0);
`endif
        tick(); idle();
        chk("byp_after", bus.pa, 32'h55);

        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom % 150) != 0;
            bus.ra      = 5'($urandom);
            bus.rb      = ($urandom % 4 == 0) ? bus.ra : 5'($urandom);
            bus.rd      = ($urandom % 4 == 0) ? bus.ra : 5'($urandom);
            bus.wr_data = $urandom;
            bus.rf_ld   = $urandom % 2;
            bus.save    = ($urandom % 3) == 0;
            bus.restore = ($urandom % 3) == 0;
            bus.cwp_ld  = ($urandom % 16) == 0;
            bus.cwp_in  = CW'($urandom);
            bus.wim_ld  = ($urandom % 20) == 0;
            bus.wim_in  = ($urandom % 3 == 0) ? N'($urandom)
                        : N'(1) << $urandom_range(0, N - 1);
            tick();
        end

        idle(); rst_n = 1; tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
